// File: rtl/regfile_pkg.sv
// Shared widths and constants for the register file, plus the 3-to-8
// decode stage used to build the write-select decoder.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  function automatic logic [7:0] dec3_8(input logic en, input logic [2:0] sel);
    dec3_8 = en ? (8'b1 << sel) : 8'b0;
  endfunction

endpackage

// File: rtl/regfile_decoder_five.sv
// 5-to-32 one-hot decoder with enable: sel[4:3] picks one of four 3-to-8 stages.
module decoder_five
  import regfile_pkg::*;
(
  input  logic        en,
  input  logic [4:0]  sel,
  output logic [31:0] out
);

  logic [3:0] bank_en;

  always_comb begin
    bank_en = '0;
    bank_en[sel[4:3]] = en;
  end

  for (genvar b = 0; b < 4; b++) begin : g_stage
    assign out[b*8 +: 8] = dec3_8(bank_en[b], sel[2:0]);
  end

endmodule

// File: rtl/regfile.sv
// Two-read, one-write register file with r0 hardwired to zero, write-through
// bypass on both read ports and a per-register busy scoreboard.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ctrl_writeEnable,
  input  logic [4:0]        ctrl_writeReg,
  input  logic [DATA_W-1:0] data_writeReg,
  input  logic [4:0]        ctrl_readRegA,
  input  logic [4:0]        ctrl_readRegB,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB,
  input  logic              ctrl_issueEnable,
  input  logic [4:0]        ctrl_issueReg,
  output logic              busy_A,
  output logic              busy_B
);

  logic [DATA_W-1:0]   regs [1:NUM_REGS-1];
  logic [NUM_REGS-1:1] busy_q;
  logic [NUM_REGS-1:0] busy;
  logic [31:0]         wsel;
  logic                unused_wsel0;

  decoder_five u_wdec (
    .en  (ctrl_writeEnable),
    .sel (ctrl_writeReg),
    .out (wsel)
  );

  assign unused_wsel0 = wsel[0];
  assign busy = {busy_q, 1'b0};

  // Issue is applied after the writeback clear so a same-register pair stays busy.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i]   <= '0;
        busy_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wsel[i])
          regs[i] <= data_writeReg;
        busy_q[i] <= (busy_q[i] & ~wsel[i]) |
                     (ctrl_issueEnable && (ctrl_issueReg == 5'(i)));
      end
    end
  end

  logic hit_a, hit_b;

  assign hit_a = ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegA);
  assign hit_b = ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegB);

  always_comb begin
    data_readRegA = '0;
    data_readRegB = '0;
    if (ctrl_readRegA != REG_ZERO)
      data_readRegA = hit_a ? data_writeReg : regs[ctrl_readRegA];
    if (ctrl_readRegB != REG_ZERO)
      data_readRegB = hit_b ? data_writeReg : regs[ctrl_readRegB];
  end

  assign busy_A = busy[ctrl_readRegA] & ~hit_a;
  assign busy_B = busy[ctrl_readRegB] & ~hit_b;

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized traffic
// compared against an array-based model of the register/scoreboard rules.
module tb_regfile;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;
  logic        ctrl_issueEnable;
  logic [4:0]  ctrl_issueReg;
  logic        busy_A;
  logic        busy_B;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_regs [32];
  logic        m_busy [32];

  regfile dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB),
    .ctrl_issueEnable (ctrl_issueEnable),
    .ctrl_issueReg    (ctrl_issueReg),
    .busy_A           (busy_A),
    .busy_B           (busy_B)
  );

  always #5 clock = ~clock;

  // Expected read value: r0 is zero, a same-cycle write to the index wins, else stored value.
  function automatic logic [31:0] exp_read(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (ctrl_writeEnable && ctrl_writeReg == idx) return data_writeReg;
    return m_regs[idx];
  endfunction

  function automatic logic exp_busy(input logic [4:0] idx);
    return m_busy[idx] && !(ctrl_writeEnable && ctrl_writeReg == idx);
  endfunction

  task automatic tick();
    @(posedge clock);
    if (ctrl_reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'h0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (ctrl_writeEnable && ctrl_writeReg != 0) begin
        m_regs[ctrl_writeReg] = data_writeReg;
        m_busy[ctrl_writeReg] = 1'b0;
      end
      if (ctrl_issueEnable && ctrl_issueReg != 0)
        m_busy[ctrl_issueReg] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    ctrl_reset = 1'b0;
    ctrl_writeEnable = 1'b0;
    ctrl_issueEnable = 1'b0;
    ctrl_writeReg = 5'd0;
    ctrl_issueReg = 5'd0;
    data_writeReg = 32'h0;
  endtask

  task automatic test_reset();
    idle();
    ctrl_readRegA = 5'd0;
    ctrl_readRegB = 5'd0;
    ctrl_reset = 1'b1;
    tick();
    tick();
    ctrl_reset = 1'b0;
    for (int i = 0; i < 32; i += 5) begin
      ctrl_readRegA = 5'(i);
      ctrl_readRegB = 5'(31 - i);
      #1;
      checks++;
      if (data_readRegA !== 32'h0 || data_readRegB !== 32'h0 || busy_A !== 1'b0 || busy_B !== 1'b0) begin
        failures++;
        $display("FAIL reset_state idx=%0d got A=%h B=%h bA=%b bB=%b want all zero",
                 i, data_readRegA, data_readRegB, busy_A, busy_B);
      end
    end
  endtask

  task automatic test_write_read();
    idle();
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg = 5'd5;
    data_writeReg = 32'hDEADBEEF;
    tick();
    idle();
    ctrl_readRegA = 5'd5;
    ctrl_readRegB = 5'd0;
    #1;
    checks++;
    if (data_readRegA !== 32'hDEADBEEF || data_readRegB !== 32'h0) begin
      failures++;
      $display("FAIL write_read got A=%h B=%h want A=deadbeef B=0", data_readRegA, data_readRegB);
    end
  endtask

  task automatic test_r0();
    idle();
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg = 5'd0;
    data_writeReg = 32'h12345678;
    ctrl_readRegA = 5'd0;
    #1;
    checks++;
    if (data_readRegA !== 32'h0) begin
      failures++;
      $display("FAIL r0_write_cycle got %h want 0", data_readRegA);
    end
    tick();
    idle();
    #1;
    checks++;
    if (data_readRegA !== 32'h0) begin
      failures++;
      $display("FAIL r0_next_cycle got %h want 0", data_readRegA);
    end
  endtask

  task automatic test_bypass();
    idle();
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg = 5'd7;
    data_writeReg = 32'hA5A5A5A5;
    ctrl_readRegA = 5'd7;
    ctrl_readRegB = 5'd7;
    #1;
    checks++;
    if (data_readRegA !== 32'hA5A5A5A5 || data_readRegB !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL bypass got A=%h B=%h want a5a5a5a5", data_readRegA, data_readRegB);
    end
    tick();
    idle();
  endtask

  task automatic test_busy();
    idle();
    ctrl_issueEnable = 1'b1;
    ctrl_issueReg = 5'd9;
    tick();
    idle();
    ctrl_readRegA = 5'd9;
    #1;
    checks++;
    if (busy_A !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_issue got %b want 1", busy_A);
    end
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg = 5'd9;
    data_writeReg = 32'h1;
    #1;
    checks++;
    if (busy_A !== 1'b0 || data_readRegA !== 32'h1) begin
      failures++;
      $display("FAIL busy_wb_cycle got busy=%b data=%h want busy=0 data=1", busy_A, data_readRegA);
    end
    tick();
    idle();
    #1;
    checks++;
    if (busy_A !== 1'b0 || data_readRegA !== 32'h1) begin
      failures++;
      $display("FAIL busy_after_wb got busy=%b data=%h want busy=0 data=1", busy_A, data_readRegA);
    end
  endtask

  task automatic test_issue_wb();
    idle();
    ctrl_issueEnable = 1'b1;
    ctrl_issueReg = 5'd3;
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg = 5'd3;
    data_writeReg = 32'h33;
    tick();
    idle();
    ctrl_readRegA = 5'd3;
    #1;
    checks++;
    if (busy_A !== 1'b1 || data_readRegA !== 32'h33) begin
      failures++;
      $display("FAIL issue_wb_same got busy=%b data=%h want busy=1 data=33", busy_A, data_readRegA);
    end
    ctrl_issueEnable = 1'b1;
    ctrl_issueReg = 5'd4;
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg = 5'd3;
    data_writeReg = 32'h44;
    tick();
    idle();
    ctrl_readRegA = 5'd4;
    ctrl_readRegB = 5'd3;
    #1;
    checks++;
    if (busy_A !== 1'b1 || busy_B !== 1'b0) begin
      failures++;
      $display("FAIL issue_wb_diff got busy4=%b busy3=%b want busy4=1 busy3=0", busy_A, busy_B);
    end
  endtask

  task automatic test_reset_override();
    idle();
    for (int i = 1; i < 32; i++) begin
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg = 5'(i);
      data_writeReg = 32'(i);
      ctrl_issueEnable = 1'b1;
      ctrl_issueReg = 5'(32 - i);
      tick();
    end
    idle();
    ctrl_readRegA = 5'd17;
    #1;
    checks++;
    if (data_readRegA !== 32'd17) begin
      failures++;
      $display("FAIL fill_value got %h want 11", data_readRegA);
    end
    ctrl_reset = 1'b1;
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg = 5'd2;
    data_writeReg = 32'hFFFF;
    ctrl_issueEnable = 1'b1;
    ctrl_issueReg = 5'd6;
    tick();
    idle();
    for (int i = 0; i < 32; i++) begin
      ctrl_readRegA = 5'(i);
      ctrl_readRegB = 5'(31 - i);
      #1;
      checks++;
      if (data_readRegA !== 32'h0 || data_readRegB !== 32'h0 || busy_A !== 1'b0 || busy_B !== 1'b0) begin
        failures++;
        $display("FAIL reset_override idx=%0d got A=%h B=%h bA=%b bB=%b want all zero",
                 i, data_readRegA, data_readRegB, busy_A, busy_B);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ea, eb;
    logic        ba, bb;
    for (int n = 0; n < 400; n++) begin
      ctrl_reset       = ($urandom_range(0, 49) == 0);
      ctrl_writeEnable = $urandom_range(0, 1);
      ctrl_writeReg    = 5'($urandom_range(0, 31));
      data_writeReg    = $urandom;
      ctrl_issueEnable = $urandom_range(0, 1);
      ctrl_issueReg    = ($urandom_range(0, 3) == 0) ? ctrl_writeReg : 5'($urandom_range(0, 31));
      ctrl_readRegA    = ($urandom_range(0, 2) == 0) ? ctrl_writeReg : 5'($urandom_range(0, 31));
      ctrl_readRegB    = ($urandom_range(0, 3) == 0) ? ctrl_readRegA : 5'($urandom_range(0, 31));
      #1;
      ea = exp_read(ctrl_readRegA);
      eb = exp_read(ctrl_readRegB);
      ba = exp_busy(ctrl_readRegA);
      bb = exp_busy(ctrl_readRegB);
      checks++;
      if (data_readRegA !== ea || data_readRegB !== eb || busy_A !== ba || busy_B !== bb) begin
        failures++;
        $display("FAIL random n=%0d ra=%0d rb=%0d got A=%h B=%h bA=%b bB=%b want A=%h B=%h bA=%b bB=%b",
                 n, ctrl_readRegA, ctrl_readRegB, data_readRegA, data_readRegB, busy_A, busy_B,
                 ea, eb, ba, bb);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_busy[i] = 1'b0;
    end
    idle();
    ctrl_readRegA = 5'd0;
    ctrl_readRegB = 5'd0;
    test_reset();
    test_write_read();
    test_r0();
    test_bypass();
    test_busy();
    test_issue_wb();
    test_reset_override();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
